// File: rtl/sipo_deserializer_if.sv
// Bit-stream and word-output signals for sipo_deserializer.
// The slave modport is the deserializer; the master modport is the producer/consumer.
interface sipo_deserializer_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             din;
    logic             din_valid;
    logic             flush;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             parity_err;
    logic             overrun;

    modport master (
        output din, din_valid, flush, out_ready,
        input  out_data, out_valid, parity_err, overrun
    );

    modport slave (
        input  din, din_valid, flush, out_ready,
        output out_data, out_valid, parity_err, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer with a single-word valid/ready output slot.
// Define SIPO_PARITY_EN to expect one even-parity bit after each word.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    sipo_deserializer_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
    typedef enum logic [0:0] {StCollect, StParity} state_e;
`else
    typedef enum logic [0:0] {StCollect} state_e;
`endif

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d, shift_in;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             overrun_q, overrun_d;
    logic             word_done;
    logic             word_perr;
    logic [WIDTH-1:0] word;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StCollect;
            cnt_q        <= '0;
            shift_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        if (MSB_FIRST) begin
            shift_in = {shift_q[WIDTH-2:0], bus.din};
        end else begin
            shift_in = {bus.din, shift_q[WIDTH-1:1]};
        end
    end

    // Collection FSM; flush wins over a same-edge strobe so that bit is dropped.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        word_perr = 1'b0;
        word      = shift_in;
        if (bus.flush) begin
            state_d = StCollect;
            cnt_d   = '0;
            shift_d = '0;
        end else if (bus.din_valid) begin
            case (state_q)
                StCollect: begin
                    shift_d = shift_in;
                    if (cnt_q == LastCnt) begin
                        cnt_d = '0;
`ifdef SIPO_PARITY_EN
                        state_d = StParity;
`else
                        word_done = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
`ifdef SIPO_PARITY_EN
                StParity: begin
                    word      = shift_q;
                    word_perr = ^{shift_q, bus.din};
                    word_done = 1'b1;
                    shift_d   = '0;
                    state_d   = StCollect;
                end
`endif
                default: state_d = StCollect;
            endcase
        end
    end

    // Output slot: a finished word loads if the slot is empty or draining this edge.
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (word_done) begin
            if (!out_valid_q || bus.out_ready) begin
                out_data_d   = word;
                out_valid_d  = 1'b1;
                parity_err_d = word_perr;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: MSB-first instance driven from a vector table,
// plus an LSB-first instance and hand-written reset/bit-order/parity sequences.
module tb_sipo_deserializer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(8)) bus_a ();
    sipo_deserializer_if #(.WIDTH(8)) bus_b ();

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

`ifdef SIPO_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    typedef enum int {PreNone, PreReset, PreFlush} pre_e;

    typedef struct {
        pre_e       pre;
        int         nbits;
        logic [7:0] word;
        logic       rdy;
        logic       rdy_last;
        logic       pre_valid;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ovr;
    } vec_t;

    localparam int NVec = 14;
    vec_t vec [NVec];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int r, input vec_t v);
        int         total;
        logic       b;
        logic [7:0] w;
        w = v.word;
        if (v.pre == PreReset) begin
            reset = 1'b0;
            bus_a.din_valid = 1'b1;
            bus_a.din       = 1'b1;
            bus_a.out_ready = 1'b0;
            step();
            reset = 1'b1;
            bus_a.din_valid = 1'b0;
        end else if (v.pre == PreFlush) begin
            bus_a.flush     = 1'b1;
            bus_a.din_valid = 1'b1;
            bus_a.din       = 1'b1;
            bus_a.out_ready = v.rdy;
            step();
            bus_a.flush     = 1'b0;
            bus_a.din_valid = 1'b0;
            chk($sformatf("vec%0d flush valid", r), 32'(bus_a.out_valid), 32'(v.pre_valid));
        end
        if (v.nbits == 0) begin
            bus_a.din_valid = 1'b0;
            bus_a.out_ready = v.rdy_last;
            step();
        end else begin
            total = v.nbits + ((ParEn && v.nbits == 8) ? 1 : 0);
            for (int i = 0; i < total; i++) begin
                b = (i < v.nbits) ? w[7-i] : ^w;
                bus_a.din_valid = 1'b1;
                bus_a.din       = b;
                bus_a.out_ready = (i == total - 1) ? v.rdy_last : v.rdy;
                step();
                if (i != total - 1) begin
                    chk($sformatf("vec%0d bit%0d valid", r, i), 32'(bus_a.out_valid),
                        32'(v.pre_valid));
                end
            end
            bus_a.din_valid = 1'b0;
        end
        bus_a.out_ready = 1'b0;
        chk($sformatf("vec%0d valid", r), 32'(bus_a.out_valid), 32'(v.exp_valid));
        chk($sformatf("vec%0d data", r), 32'(bus_a.out_data), 32'(v.exp_data));
        chk($sformatf("vec%0d overrun", r), 32'(bus_a.overrun), 32'(v.exp_ovr));
        chk($sformatf("vec%0d parity_err", r), 32'(bus_a.parity_err), 32'(1'b0));
    endtask

    task automatic send_a(input logic [7:0] w, input logic par, input logic rdy);
        for (int i = 0; i < 8 + (ParEn ? 1 : 0); i++) begin
            bus_a.din_valid = 1'b1;
            bus_a.din       = (i < 8) ? w[7-i] : par;
            bus_a.out_ready = rdy;
            step();
        end
        bus_a.din_valid = 1'b0;
        bus_a.out_ready = 1'b0;
    endtask

    initial begin
        logic [8:0] bits_b;

        //           pre       n  word   rdy   rdyl  prev  expv  data   ovr
        vec[0]  = '{PreNone,  8, 8'hC5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC5, 1'b0};
        vec[1]  = '{PreNone,  0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC5, 1'b0};
        vec[2]  = '{PreNone,  8, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
        vec[3]  = '{PreNone,  8, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
        vec[4]  = '{PreNone,  0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1};
        vec[5]  = '{PreReset, 8, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0};
        vec[6]  = '{PreNone,  8, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 1'b0};
        vec[7]  = '{PreNone,  0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0};
        vec[8]  = '{PreNone,  5, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 1'b0};
        vec[9]  = '{PreFlush, 8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0};
        vec[10] = '{PreNone,  7, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0};
        vec[11] = '{PreFlush, 8, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0};
        vec[12] = '{PreNone,  8, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0};
        vec[13] = '{PreNone,  8, 8'hE1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hE1, 1'b0};

        reset = 1'b0;
        bus_a.din = 1'b0; bus_a.din_valid = 1'b0; bus_a.flush = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.din = 1'b0; bus_b.din_valid = 1'b0; bus_b.flush = 1'b0; bus_b.out_ready = 1'b0;
        step();
        step();
        chk("reset valid", 32'(bus_a.out_valid), 32'(1'b0));
        chk("reset data", 32'(bus_a.out_data), 32'(8'h00));
        chk("reset overrun", 32'(bus_a.overrun), 32'(1'b0));
        chk("reset parity_err", 32'(bus_a.parity_err), 32'(1'b0));
        reset = 1'b1;

        // Three bits, then a reset that also carries a strobe; the next word must align afresh.
        for (int i = 0; i < 3; i++) begin
            bus_a.din_valid = 1'b1;
            bus_a.din       = (i != 1);
            step();
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus_a.din_valid = 1'b0;
        chk("midword reset valid", 32'(bus_a.out_valid), 32'(1'b0));

        for (int r = 0; r < NVec; r++) begin
            run_vec(r, vec[r]);
        end

        // LSB-first instance: bits 1,1,0,0,0,1,0,1 then (even) parity 0.
        bits_b = 9'b0_1010_0011;
        for (int i = 0; i < 8 + (ParEn ? 1 : 0); i++) begin
            bus_b.din_valid = 1'b1;
            bus_b.din       = bits_b[i];
            step();
        end
        bus_b.din_valid = 1'b0;
        chk("lsb_first valid", 32'(bus_b.out_valid), 32'(1'b1));
        chk("lsb_first data", 32'(bus_b.out_data), 32'(8'hA3));
        chk("lsb_first parity_err", 32'(bus_b.parity_err), 32'(1'b0));

        // 0x07 has three ones: parity bit 1 is correct, 0 is a mismatch.
        send_a(8'h07, 1'b1, 1'b1);
        chk("par good valid", 32'(bus_a.out_valid), 32'(1'b1));
        chk("par good data", 32'(bus_a.out_data), 32'(8'h07));
        chk("par good parity_err", 32'(bus_a.parity_err), 32'(1'b0));
        send_a(8'h07, 1'b0, 1'b1);
        chk("par bad valid", 32'(bus_a.out_valid), 32'(1'b1));
        chk("par bad data", 32'(bus_a.out_data), 32'(8'h07));
        chk("par bad parity_err", 32'(bus_a.parity_err), 32'(ParEn));
        chk("par overrun", 32'(bus_a.overrun), 32'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out deserializer that sits directly downstream of the single-bit enable flip-flop stage. It consumes the registered data bit plus its qualifying strobe and assembles `WIDTH`-bit words. Completed words are presented on a valid/ready output port with one word of output buffering. It also reports overrun and optional parity errors.

## Interface
- `WIDTH`, 8: data bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 means the first received bit lands in `out_data[WIDTH-1]`; 0 means it lands in `out_data[0]`.

- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on rising `clk`; no asynchronous path.
- `din` input 1: serial data bit, normally the flip-flop stage output.
- `din_valid` input 1: bit strobe; `din` is consumed on an edge where this is 1.
- `flush` input 1: synchronous abort of the partially assembled word.
- `out_data` output `WIDTH`: assembled word.
- `out_valid` output 1: `out_data` holds an unconsumed word.
- `out_ready` input 1: consumer accepts the word.
- `parity_err` output 1: parity status of the word in `out_data`; qualified by `out_valid`.
- `overrun` output 1: sticky flag; a completed word was dropped.

## Operation
- Reset (`reset`=0 at an edge): `out_data`=0, `out_valid`=0, `parity_err`=0, `overrun`=0.
  - Bit counter and shift register clear; FSM enters `COLLECT`.
  - Reset has priority over every other input.
- FSM states:
  - `COLLECT`: receiving data bits.
  - `PARITY`: awaiting the parity bit; this state exists only with `SIPO_PARITY_EN`.
- Bit capture: each edge with `din_valid`=1 shifts `din` into the shift register and increments the bit counter (0..`WIDTH`-1).
  - With `MSB_FIRST`=1, the register shifts left and takes `din` at the LSB.
  - With `MSB_FIRST`=0, the register shifts right and takes `din` at the MSB.
- Word completion: on the edge capturing the final bit, the counter wraps to 0 and the word is complete.
  - The final bit is the last data bit, or the parity bit when `SIPO_PARITY_EN` is defined.
- Load rule: a complete word loads into `out_data` and sets `out_valid`=1 if the output slot is free.
  - The slot is free if `out_valid`=0, or if `out_valid`=1 and `out_ready`=1 on the same edge.
- Overrun: if a word completes while `out_valid`=1 and `out_ready`=0, the new word is discarded.
  - `out_data` is unchanged and `overrun` is set to 1.
  - `overrun` is sticky until reset.
  - Collection of the next word continues normally.
- Handshake:
  - A transfer occurs on an edge with `out_valid`=1 and `out_ready`=1.
  - `out_valid` falls after a transfer unless a word loads on that same edge, in which case it stays 1 with the new data.
  - `out_data` is stable while `out_valid`=1 and not yet transferred.
- Flush: `flush`=1 clears the bit counter and shift register and returns the FSM to `COLLECT`.
  - If `din_valid`=1 on the same edge, that bit is discarded.
  - If the flush edge would have completed a word, no word is produced.
  - `out_valid`, `out_data`, `parity_err` and `overrun` are unaffected.
- `din_valid`=0: holds all collection state indefinitely; there is no timeout.

## Timing
- Latency: `out_valid` is 1 in the cycle immediately after the edge that captured the final bit.
- Maximum throughput is one bit per clock.
  - With back-to-back words at full rate, a consumer with `out_ready` tied to 1 never sees an overrun.
- `out_ready` may be asserted before `out_valid`; no combinational path runs from `out_ready` to `out_valid`.
- All outputs are registered.

## Configuration
- `SIPO_PARITY_EN` defined:
  - Each frame is `WIDTH` data bits followed by one even-parity bit, taken in the `PARITY` state.
  - `parity_err` loads with the word and equals XOR(data bits, parity bit), so 1 means a mismatch.
  - Word-completion latency counts from the parity-bit edge.
  - The parity bit is not stored in `out_data`.
- `SIPO_PARITY_EN` undefined:
  - Frames are `WIDTH` bits and the `PARITY` state does not exist.
  - `parity_err` is constant 0.

## Test plan
- Reset mid-word: reset after 3 bits, then send 8 bits 0xC5 MSB-first -> `out_data`=0xC5, `out_valid`=1 one cycle after the 8th bit, `overrun`=0.
- Bit order: with `MSB_FIRST`=0, send bits 1,1,0,0,0,1,0,1 in that order -> `out_data`=0xA3.
- Backpressure: hold `out_ready`=0 and send two words 0x11 then 0x22 -> `out_data` stays 0x11 and `overrun`=1 on the 0x22 completion edge; raising `out_ready` then clears `out_valid`.
- Simultaneous load and transfer: with word 0x33 held, the final bit of 0x44 arrives on the same edge as `out_ready`=1 -> `out_valid` stays 1, `out_data`=0x44, `overrun`=0.
- Flush: send 5 bits, pulse `flush` together with `din_valid`, then send 0x5A -> `out_data`=0x5A, with no spurious word produced.
- Parity (`SIPO_PARITY_EN`): send 0x07 with parity bit 1 -> `parity_err`=0; resend with parity bit 0 -> `parity_err`=1.
